// File: rtl/clut_loader.sv
// CLUT palette transfer engine: bulk load (s_* stream -> CLUT) or dump (CLUT -> m_* stream) over the CLUT system port; load 1 entry/cycle, dump 1 entry/2 cycles.
// Stalls on s_valid low / m_ready low. Define CLUT_LOADER_VBLANK_EN to hold loads until the next frame_start strobe.
module clut_loader #(
  parameter int ADDRW = 8,
  parameter int DATAW = 15
) (
  input  logic             clk_sys,
  input  logic             rst_sys,
  input  logic             start,
  input  logic             mode,
  input  logic [ADDRW-1:0] base,
  input  logic [ADDRW:0]   len,
  input  logic             frame_start,
  output logic             busy,
  output logic             done,
  input  logic [DATAW-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [DATAW-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             clut_we,
  output logic             clut_re,
  output logic [ADDRW-1:0] clut_addr,
  output logic [DATAW-1:0] clut_din,
  input  logic [DATAW-1:0] clut_dout
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VBL,
    LOAD,
    FLUSH,
    READ,
    RESP,
    DONE
  } state_t;

  localparam logic [ADDRW:0] REM_ONE = {{ADDRW{1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [ADDRW-1:0] addr;
  logic [ADDRW:0]   remaining;
  logic             we_q;
  logic [ADDRW-1:0] wr_addr_q;
  logic [DATAW-1:0] wr_din_q;
  logic             load_beat;
  logic             dump_beat;

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    clut_re   = 1'b0;
    load_beat = 1'b0;
    dump_beat = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (len == '0)
            state_nxt = DONE;
          else if (mode)
            state_nxt = READ;
          else
`ifdef CLUT_LOADER_VBLANK_EN
            state_nxt = WAIT_VBL;
`else
            state_nxt = LOAD;
`endif
        end
      end
      // Only reachable when vblank gating is built in; frame_start in IDLE never counts.
      WAIT_VBL: begin
        if (frame_start)
          state_nxt = LOAD;
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          load_beat = 1'b1;
          if (remaining == REM_ONE)
            state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        state_nxt = DONE;
      end
      READ: begin
        clut_re   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        m_valid = 1'b1;
        if (m_ready) begin
          dump_beat = 1'b1;
          state_nxt = (remaining == REM_ONE) ? DONE : READ;
        end
      end
      DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // clut_dout holds while clut_re is low, so RESP can pass it straight through.
  assign m_data    = clut_dout;
  assign clut_we   = we_q;
  assign clut_din  = wr_din_q;
  assign clut_addr = (state == READ) ? addr : wr_addr_q;

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_din_q  <= '0;
    end else begin
      state <= state_nxt;
      we_q  <= load_beat;
      if (state == IDLE && start) begin
        addr      <= base;
        remaining <= len;
      end
      if (load_beat) begin
        wr_addr_q <= addr;
        wr_din_q  <= s_data;
      end
      // Address wraps naturally at DEPTH through the ADDRW-bit counter.
      if (load_beat || dump_beat) begin
        addr      <= addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clut_loader.sv
// Scoreboard bench for clut_loader: stimulus pushes expected CLUT writes/reads, stream beats and done pulses; a negedge monitor pops and compares.
module tb_clut_loader;
  localparam int ADDRW = 8;
  localparam int DATAW = 15;
`ifdef CLUT_LOADER_VBLANK_EN
  localparam int VOFF = 1;
`else
  localparam int VOFF = 0;
`endif

  logic             clk_sys = 1'b0;
  logic             rst_sys;
  logic             start;
  logic             mode;
  logic [ADDRW-1:0] base;
  logic [ADDRW:0]   len;
  logic             frame_start;
  logic             busy;
  logic             done;
  logic [DATAW-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic [DATAW-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             clut_we;
  logic             clut_re;
  logic [ADDRW-1:0] clut_addr;
  logic [DATAW-1:0] clut_din;
  logic [DATAW-1:0] clut_dout;

  clut_loader #(.ADDRW(ADDRW), .DATAW(DATAW)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .start(start), .mode(mode), .base(base), .len(len),
    .frame_start(frame_start), .busy(busy), .done(done), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .clut_we(clut_we),
    .clut_re(clut_re), .clut_addr(clut_addr), .clut_din(clut_din), .clut_dout(clut_dout)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // CLUT system port model: synchronous write, registered read that holds while clut_re is low.
  logic [DATAW-1:0] mem [256];
  always @(posedge clk_sys) begin
    if (clut_we) mem[clut_addr] <= clut_din;
    if (clut_re) clut_dout <= mem[clut_addr];
  end

  typedef struct {
    int cyc;
    int addr;
    int data;
  } ev_t;

  ev_t wr_q[$];
  ev_t re_q[$];
  ev_t rd_q[$];
  int  done_q[$];
  int  img[256];
  int  checks = 0;
  int  errors = 0;
  int  s_rdy_cnt = 0;
  int  m_vld_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_sys) begin
    ev_t e;
    if (clut_we || clut_re) chk("we_re_exclusive", int'(clut_we && clut_re), 0);
    if (clut_we) begin
      chk("write_expected", int'(wr_q.size() > 0), 1);
      if (wr_q.size() > 0) begin
        e = wr_q.pop_front();
        chk("wr_cyc", cyc, e.cyc);
        chk("wr_addr", int'(clut_addr), e.addr);
        chk("wr_data", int'(clut_din), e.data);
      end
    end
    if (clut_re) begin
      chk("read_expected", int'(re_q.size() > 0), 1);
      if (re_q.size() > 0) begin
        e = re_q.pop_front();
        chk("re_cyc", cyc, e.cyc);
        chk("re_addr", int'(clut_addr), e.addr);
      end
    end
    if (m_valid) begin
      m_vld_cnt++;
      chk("beat_expected", int'(rd_q.size() > 0), 1);
      if (rd_q.size() > 0) begin
        if (m_ready) begin
          e = rd_q.pop_front();
          chk("m_accept_cyc", cyc, e.cyc);
          chk("m_data", int'(m_data), e.data);
        end else begin
          chk("m_data_stall", int'(m_data), rd_q[0].data);
        end
      end
    end
    if (done) begin
      chk("done_expected", int'(done_q.size() > 0), 1);
      if (done_q.size() > 0) chk("done_cyc", cyc, done_q.pop_front());
    end
    if (s_ready) s_rdy_cnt++;
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic exp_wr(input int c, input int a, input int d);
    wr_q.push_back('{c, a & 255, d});
    img[a & 255] = d;
  endtask

  task automatic exp_beat(input int re_c, input int acc_c, input int a);
    re_q.push_back('{re_c, a & 255, 0});
    rd_q.push_back('{acc_c, a & 255, img[a & 255]});
  endtask

  // Start pulse; in vblank builds a load also gets a frame_start the following cycle.
  task automatic kick(input logic m, input logic [ADDRW-1:0] b, input logic [ADDRW:0] n);
    start = 1'b1;
    mode  = m;
    base  = b;
    len   = n;
    tick();
    start = 1'b0;
    if (VOFF != 0 && m == 1'b0) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
    end
  endtask

  int t1[4] = '{'h7FFF, 'h001F, 'h03E0, 'h7C00};
  int t2[3] = '{'h1234, 'h2345, 'h3456};
  int t3[3] = '{'h0A5A, 'h15A5, 'h7001};

  initial begin
    int s;
    int ld;
    int sr0;
    int mv0;
    int bcyc;
    rst_sys = 1'b1;
    start = 1'b0; mode = 1'b0; base = '0; len = '0; frame_start = 1'b0;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b1;
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_clut_we", int'(clut_we), 0);
    chk("rst_clut_re", int'(clut_re), 0);
    chk("rst_clut_addr", int'(clut_addr), 0);
    chk("rst_clut_din", int'(clut_din), 0);
    rst_sys = 1'b0;
    tick();

    // Load base 0x10, len 4, s_valid held high.
    s = cyc; ld = s + 1 + VOFF;
    for (int i = 0; i < 4; i++) exp_wr(ld + 1 + i, 'h10 + i, t1[i]);
    done_q.push_back(ld + 5);
    kick(1'b0, 8'h10, 9'd4);
    chk("load_s_ready", int'(s_ready), 1);
    chk("load_busy", int'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = DATAW'(t1[i]); tick();
    end
    s_valid = 1'b0;
    chk("flush_s_ready", int'(s_ready), 0);
    repeat (4) tick();

    // Load across the wrap with s_valid toggling.
    s = cyc; ld = s + 1 + VOFF;
    for (int i = 0; i < 3; i++) exp_wr(ld + 1 + 2 * i, 'hFF + i, t2[i]);
    done_q.push_back(ld + 6);
    kick(1'b0, 8'hFF, 9'd3);
    for (int k = 0; k < 5; k++) begin
      s_valid = (k % 2 == 0);
      s_data  = (k % 2 == 0) ? DATAW'(t2[k / 2]) : 15'h7777;
      tick();
    end
    s_valid = 1'b0;
    repeat (4) tick();

    // Preload 0x20..0x22, then dump with a 5-cycle stall on the second beat.
    s = cyc; ld = s + 1 + VOFF;
    for (int i = 0; i < 3; i++) exp_wr(ld + 1 + i, 'h20 + i, t3[i]);
    done_q.push_back(ld + 4);
    kick(1'b0, 8'h20, 9'd3);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = DATAW'(t3[i]); tick();
    end
    s_valid = 1'b0;
    repeat (4) tick();
    s = cyc;
    exp_beat(s + 1, s + 2, 'h20);
    exp_beat(s + 3, s + 9, 'h21);
    exp_beat(s + 10, s + 11, 'h22);
    done_q.push_back(s + 12);
    kick(1'b1, 8'h20, 9'd3);
    while (cyc <= s + 13) begin
      m_ready = !(cyc >= s + 4 && cyc <= s + 8);
      tick();
    end
    m_ready = 1'b1;

    // Dump across the wrap, then dump the first load region.
    s = cyc;
    for (int i = 0; i < 2; i++) exp_beat(s + 1 + 2 * i, s + 2 + 2 * i, 'hFF + i);
    done_q.push_back(s + 5);
    kick(1'b1, 8'hFF, 9'd2);
    repeat (6) tick();
    s = cyc;
    for (int i = 0; i < 4; i++) exp_beat(s + 1 + 2 * i, s + 2 + 2 * i, 'h10 + i);
    done_q.push_back(s + 9);
    kick(1'b1, 8'h10, 9'd4);
    repeat (10) tick();

    // len = 0 in both modes: done only, no port or stream activity.
    for (int m = 0; m < 2; m++) begin
      sr0 = s_rdy_cnt; mv0 = m_vld_cnt;
      s = cyc;
      done_q.push_back(s + 1);
      kick(m[0], 8'h33, 9'd0);
      repeat (3) tick();
      chk("len0_s_ready_cnt", s_rdy_cnt, sr0);
      chk("len0_m_valid_cnt", m_vld_cnt, mv0);
    end

    // Reset after 2 of 8 beats; a start issued while busy must be ignored.
    s = cyc; ld = s + 1 + VOFF;
    exp_wr(ld + 1, 'h40, 'h1111);
    exp_wr(ld + 2, 'h41, 'h2222);
    kick(1'b0, 8'h40, 9'd8);
    s_valid = 1'b1; s_data = 15'h1111;
    start = 1'b1; mode = 1'b1; base = 8'h00; len = 9'd5;
    tick();
    start = 1'b0;
    s_data = 15'h2222;
    tick();
    s_valid = 1'b0;
    rst_sys = 1'b1;
    tick();
    chk("abort_busy", int'(busy), 0);
    chk("abort_s_ready", int'(s_ready), 0);
    chk("abort_clut_we", int'(clut_we), 0);
    chk("abort_clut_re", int'(clut_re), 0);
    chk("abort_clut_addr", int'(clut_addr), 0);
    chk("abort_clut_din", int'(clut_din), 0);
    chk("abort_done", int'(done), 0);
    rst_sys = 1'b0;
    repeat (3) tick();
    s = cyc; ld = s + 1 + VOFF;
    exp_wr(ld + 1, 'h50, 'h0123);
    exp_wr(ld + 2, 'h51, 'h0456);
    done_q.push_back(ld + 3);
    kick(1'b0, 8'h50, 9'd2);
    s_valid = 1'b1; s_data = 15'h0123; tick();
    s_data = 15'h0456; tick();
    s_valid = 1'b0;
    repeat (4) tick();

    // frame_start coincident with start, then a later frame_start at s+5.
    s = cyc;
    bcyc = (VOFF != 0) ? s + 6 : s + 1;
    exp_wr(bcyc + 1, 'h60, 'h0F0F);
    done_q.push_back(bcyc + 2);
    start = 1'b1; mode = 1'b0; base = 8'h60; len = 9'd1; frame_start = 1'b1;
    tick();
    start = 1'b0; frame_start = 1'b0; s_data = 15'h0F0F;
    while (cyc <= s + 10) begin
      frame_start = (cyc == s + 5);
      s_valid = (cyc == bcyc);
      chk("vbl_s_ready", int'(s_ready), int'(cyc == bcyc));
      tick();
    end
    frame_start = 1'b0; s_valid = 1'b0;
    repeat (3) tick();

    chk("wr_q_drained", wr_q.size(), 0);
    chk("re_q_drained", re_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
